zbt_port_arbiter: RTL and testbench

Single-port ZBT SRAM arbiter directly downstream of the NTSC-to-ZBT packer. It buffers the packer's write stream (`ntsc_we`/`ntsc_addr`/`ntsc_data`) in a small FIFO and shares the one ZBT port with the display read engine. Display reads have priority, but a starvation guard guarantees write bandwidth. It generates the ZBT command/data pipeline with the RAM's fixed 2-cycle latency.

---
 rtl/zbt_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_zbt_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_port_arbiter.sv
// zbt_port_arbiter
//   Shares the single ZBT SRAM port between the NTSC packer's write stream
//   (buffered in a small FIFO) and the display read engine. Reads win by
//   default; a starvation counter forces a write after WR_MAX_WAIT cycles
//   of a non-empty FIFO going unserviced. The ZBT has a fixed 2-cycle
//   latency: the command goes out one cycle after the slot decision, and
//   write data / read capture happen two cycles after that.
//
// Ports
//   clk, reset_n              : system clock, async active-low reset
//   ntsc_we/addr/data         : one-cycle write pushes from the packer
//   disp_req/addr             : display read request (level) and address
//   disp_ready                : read accepted when disp_req & disp_ready
//   disp_data/disp_valid      : read data, valid for one cycle per read
//   ram_addr/ram_we_b         : ZBT command (address, active-low write)
//   ram_wdata/ram_oe          : ZBT write data and its tri-state enable
//   ram_rdata                 : ZBT read data
//   fifo_level                : write FIFO occupancy
//   overflow                  : sticky, set when a push is dropped
module zbt_port_arbiter #(
    parameter int FIFO_DEPTH  = 8,
    parameter int WR_MAX_WAIT = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ntsc_we,
    input  logic [19:0]                 ntsc_addr,
    input  logic [35:0]                 ntsc_data,
    input  logic                        disp_req,
    input  logic [19:0]                 disp_addr,
    output logic                        disp_ready,
    output logic [35:0]                 disp_data,
    output logic                        disp_valid,
    output logic [18:0]                 ram_addr,
    output logic                        ram_we_b,
    output logic [35:0]                 ram_wdata,
    output logic                        ram_oe,
    input  logic [35:0]                 ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);
    localparam int DATA_W = 36;
    localparam int ADDR_W = 19;
    localparam int ENT_W  = ADDR_W + DATA_W;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(WR_MAX_WAIT + 1);

    localparam logic [AW:0]      FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(WR_MAX_WAIT);

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  starv_cnt;
    logic [ENT_W-1:0]  head;

    logic fifo_ne;
    logic fifo_full;
    logic force_wr;
    logic wr_go;
    logic rd_go;
    logic push;
    logic pop;
    logic drop;

    logic [DATA_W-1:0] wr_data_p0;
    logic [DATA_W-1:0] wr_data_p1;
    logic              wr_vld_p0;
    logic              wr_vld_p1;
    logic              rd_vld_p0;
    logic              rd_vld_p1;
    logic              rd_vld_p2;

    // Bit 19 of both address buses is outside the 19-bit ZBT space.
    logic unused_bits;
    assign unused_bits = ntsc_addr[19] ^ disp_addr[19];

    assign fifo_ne    = (fifo_level != '0);
    assign fifo_full  = (fifo_level == FULL_LVL);
    assign force_wr   = (starv_cnt == MAX_CNT);
    assign head       = fifo_mem[rd_ptr];
    // Depends only on registered state so the display engine never sees a
    // combinational loop through disp_req.
    assign disp_ready = !force_wr;

    // Slot decision
    always_comb begin
        wr_go = 1'b0;
        rd_go = 1'b0;
        if (force_wr && fifo_ne) begin
            wr_go = 1'b1;
        end else if (disp_req && !force_wr) begin
            rd_go = 1'b1;
        end else if (fifo_ne) begin
            wr_go = 1'b1;
        end
    end

    // A full FIFO still accepts a push when the same cycle pops an entry.
    assign pop  = wr_go;
    assign push = ntsc_we && (!fifo_full || pop);
    assign drop = ntsc_we && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ntsc_addr[ADDR_W-1:0], ntsc_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            starv_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
            if (drop) overflow <= 1'b1;
            if (pop || !fifo_ne) begin
                starv_cnt <= '0;
            end else if (!force_wr) begin
                starv_cnt <= starv_cnt + 1'b1;
            end
        end
    end

    // Data-only pipeline stages; their valids below gate every use.
    always_ff @(posedge clk) begin
        if (wr_go)     wr_data_p0 <= head[DATA_W-1:0];
        if (wr_vld_p0) wr_data_p1 <= wr_data_p0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr   <= '0;
            ram_we_b   <= 1'b1;
            wr_vld_p0  <= 1'b0;
            rd_vld_p0  <= 1'b0;
            wr_vld_p1  <= 1'b0;
            rd_vld_p1  <= 1'b0;
            ram_wdata  <= '0;
            ram_oe     <= 1'b0;
            rd_vld_p2  <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            // p0: command on the ZBT pins (decision + 1); idle holds address
            if (wr_go) begin
                ram_addr <= head[ENT_W-1:DATA_W];
            end else if (rd_go) begin
                ram_addr <= disp_addr[ADDR_W-1:0];
            end
            ram_we_b  <= !wr_go;
            wr_vld_p0 <= wr_go;
            rd_vld_p0 <= rd_go;

            // p1: ZBT latency slot (decision + 2)
            wr_vld_p1 <= wr_vld_p0;
            rd_vld_p1 <= rd_vld_p0;

            // p2: write data driven / read data on the bus (decision + 3)
            if (wr_vld_p1) ram_wdata <= wr_data_p1;
            ram_oe    <= wr_vld_p1;
            rd_vld_p2 <= rd_vld_p1;

            // p3: captured read data to the display (decision + 4)
            if (rd_vld_p2) disp_data <= ram_rdata;
            disp_valid <= rd_vld_p2;
        end
    end

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// tb_zbt_port_arbiter
//   Directed stimulus for zbt_port_arbiter with a scoreboard: the stimulus
//   pushes expected RAM commands, write data and read results into queues,
//   and a monitor on the falling edge pops and compares whenever the DUT
//   shows a RAM write, a driven write-data slot or a display result. A small
//   ZBT model returns a fixed function of the address two cycles after the
//   read command.
module tb_zbt_port_arbiter;
    localparam int FIFO_DEPTH  = 8;
    localparam int WR_MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ntsc_we = 1'b0;
    logic [19:0] ntsc_addr = '0;
    logic [35:0] ntsc_data = '0;
    logic        disp_req = 1'b0;
    logic [19:0] disp_addr = '0;
    logic        disp_ready;
    logic [35:0] disp_data;
    logic        disp_valid;
    logic [18:0] ram_addr;
    logic        ram_we_b;
    logic [35:0] ram_wdata;
    logic        ram_oe;
    logic [35:0] ram_rdata;
    logic [3:0]  fifo_level;
    logic        overflow;

    zbt_port_arbiter #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .WR_MAX_WAIT (WR_MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ntsc_we    (ntsc_we),
        .ntsc_addr  (ntsc_addr),
        .ntsc_data  (ntsc_data),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_ready (disp_ready),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .ram_addr   (ram_addr),
        .ram_we_b   (ram_we_b),
        .ram_wdata  (ram_wdata),
        .ram_oe     (ram_oe),
        .ram_rdata  (ram_rdata),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ZBT model: read data for the address presented in cycle n appears
    // during cycle n+2.
    function automatic logic [35:0] ram_fn(input logic [18:0] a);
        return 36'h123456789 ^ {17'h0, a ^ 19'h00456};
    endfunction

    logic [18:0] a1 = '0, a2 = '0;
    logic        r1 = 1'b1, r2 = 1'b1;
    always @(posedge clk) begin
        a1 <= ram_addr;
        r1 <= ram_we_b;
        a2 <= a1;
        r2 <= r1;
    end
    assign ram_rdata = r2 ? ram_fn(a2) : 36'hBADBADBAD;

    typedef struct { logic [18:0] addr; logic [35:0] data; int due; } wr_t;
    typedef struct { logic [35:0] data; int due; } dat_t;
    typedef struct { logic [18:0] addr; int due; } adr_t;

    wr_t  q_wr[$];
    dat_t q_wd[$];
    adr_t q_ra[$];
    dat_t q_rd[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected no such event", name, act);
    endtask

    // Scoreboard monitor
    wr_t  m_wr;
    dat_t m_d;
    adr_t m_a;
    always @(negedge clk) begin
        if (reset_n) begin
            if (q_ra.size() > 0 && q_ra[0].due <= cyc) begin
                m_a = q_ra.pop_front();
                chk("rd_cmd_cycle", cyc, m_a.due);
                chk("rd_cmd_we_b", ram_we_b, 1);
                chk("rd_cmd_addr", ram_addr, m_a.addr);
            end
            if (!ram_we_b) begin
                if (q_wr.size() == 0) begin
                    bad("wr_cmd_unexpected", ram_addr);
                end else begin
                    m_wr = q_wr.pop_front();
                    if (m_wr.due >= 0) chk("wr_cmd_cycle", cyc, m_wr.due);
                    chk("wr_cmd_addr", ram_addr, m_wr.addr);
                    m_d.data = m_wr.data;
                    m_d.due  = cyc + 2;
                    q_wd.push_back(m_d);
                end
            end
            if (ram_oe) begin
                if (q_wd.size() == 0) begin
                    bad("wr_oe_unexpected", ram_wdata);
                end else begin
                    m_d = q_wd.pop_front();
                    chk("wr_data_cycle", cyc, m_d.due);
                    chk("wr_data", ram_wdata, m_d.data);
                end
            end else if (q_wd.size() > 0 && q_wd[0].due < cyc) begin
                m_d = q_wd.pop_front();
                bad("wr_oe_missing", m_d.data);
            end
            if (disp_valid) begin
                if (q_rd.size() == 0) begin
                    bad("rd_valid_unexpected", disp_data);
                end else begin
                    m_d = q_rd.pop_front();
                    chk("rd_valid_cycle", cyc, m_d.due);
                    chk("rd_data", disp_data, m_d.data);
                end
            end else if (q_rd.size() > 0 && q_rd[0].due < cyc) begin
                m_d = q_rd.pop_front();
                bad("rd_valid_missing", m_d.data);
            end
        end
    end

    // One cycle of stimulus; inputs change on the falling edge.
    task automatic tick(input bit we, input logic [19:0] wa, input logic [35:0] wd,
                        input bit keep, input int woff,
                        input bit rq, input logic [19:0] ra, output bit acc);
        wr_t  w;
        dat_t d;
        adr_t a;
        @(negedge clk);
        ntsc_we   = we;
        ntsc_addr = wa;
        ntsc_data = wd;
        disp_req  = rq;
        disp_addr = ra;
        acc = 1'b0;
        if (we && keep) begin
            w.addr = wa[18:0];
            w.data = wd;
            w.due  = (woff >= 0) ? cyc + woff : -1;
            q_wr.push_back(w);
        end
        if (rq && disp_ready) begin
            acc    = 1'b1;
            a.addr = ra[18:0];
            a.due  = cyc + 1;
            q_ra.push_back(a);
            d.data = ram_fn(ra[18:0]);
            d.due  = cyc + 4;
            q_rd.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, -1, 1'b0, '0, acc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ram_we_b"}, ram_we_b, 1);
        chk({tag, "_ram_oe"}, ram_oe, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_disp_valid"}, disp_valid, 0);
        chk({tag, "_disp_data"}, disp_data, 0);
        chk({tag, "_disp_ready"}, disp_ready, 1);
        chk({tag, "_fifo_level"}, fifo_level, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    bit pat [20] = '{1,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1,1,1,1};

    initial begin
        bit          acc;
        int          nacc;
        logic [19:0] ra;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset_n = 1'b1;
        idle(2);

        // Single write: decision the cycle after the push
        tick(1'b1, 20'h00123, 36'h0DEADBEEF, 1'b1, 2, 1'b0, '0, acc);
        tick(1'b0, '0, '0, 1'b0, -1, 1'b0, '0, acc);
        chk("level_after_push", fifo_level, 1);
        tick(1'b0, '0, '0, 1'b0, -1, 1'b0, '0, acc);
        chk("level_after_pop", fifo_level, 0);
        idle(4);
        chk("idle_holds_addr", ram_addr, 19'h00123);
        chk("idle_we_b", ram_we_b, 1);

        // Read latency; bit 19 of the address must be ignored
        tick(1'b0, '0, '0, 1'b0, -1, 1'b1, 20'h80456, acc);
        chk("read_accepted", acc, 1);
        idle(6);
        chk("disp_valid_low_after", disp_valid, 0);
        chk("disp_data_holds", disp_data, 36'h123456789);

        // Back-to-back R W R W R W
        tick(1'b1, 20'h00A01, 36'h111111111, 1'b1, -1, 1'b0, '0, acc);
        tick(1'b1, 20'h00A02, 36'h222222222, 1'b1, -1, 1'b1, 20'h00B01, acc);
        tick(1'b1, 20'h00A03, 36'h333333333, 1'b1, -1, 1'b0, '0, acc);
        tick(1'b0, '0, '0, 1'b0, -1, 1'b1, 20'h00B02, acc);
        tick(1'b0, '0, '0, 1'b0, -1, 1'b0, '0, acc);
        tick(1'b0, '0, '0, 1'b0, -1, 1'b1, 20'h00B03, acc);
        idle(8);

        // Starvation: 3 writes under continuous reads
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 20'h00D00 + 20'(nacc);
            tick(i < 3, 20'h00C00 + 20'(i), 36'hC00000000 + 36'(i), 1'b1, -1, 1'b1, ra, acc);
            chk($sformatf("starve_ready_%0d", i), disp_ready, pat[i]);
            if (acc) nacc++;
        end
        idle(8);
        chk("starve_drained", fifo_level, 0);

        // Full FIFO with a simultaneous forced pop
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            ra = 20'h00F00 + 20'(nacc);
            tick((i <= 8) || (i == 10), 20'h01000 + 20'(i), 36'hF00000000 + 36'(i),
                 1'b1, -1, 1'b1, ra, acc);
            chk($sformatf("fullpop_ready_%0d", i), disp_ready, (i == 5 || i == 10) ? 1'b0 : 1'b1);
            if (i == 9)  chk("fullpop_level_full", fifo_level, 8);
            if (i == 11) begin
                chk("fullpop_level_kept", fifo_level, 8);
                chk("fullpop_no_overflow", overflow, 0);
            end
            if (acc) nacc++;
        end
        idle(14);
        chk("fullpop_drained", fifo_level, 0);
        chk("fullpop_overflow_clear", overflow, 0);

        // Overflow: 10 consecutive pushes, the 10th arrives full with no pop
        nacc = 0;
        for (int i = 0; i < 11; i++) begin
            ra = 20'h02000 + 20'(nacc);
            tick(i < 10, 20'h03000 + 20'(i), 36'hA00000000 + 36'(i),
                 i != 9, -1, 1'b1, ra, acc);
            if (i == 10) begin
                chk("ovf_level_peak", fifo_level, 8);
                chk("ovf_set", overflow, 1);
                chk("ovf_forced_ready", disp_ready, 0);
            end
            if (acc) nacc++;
        end
        idle(14);
        chk("ovf_drained", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset two cycles after a read is accepted, with a write in flight
        tick(1'b1, 20'h00E01, 36'h0E0E0E0E1, 1'b1, -1, 1'b1, 20'h00E55, acc);
        chk("mid_read_accepted", acc, 1);
        tick(1'b1, 20'h00E02, 36'h0E0E0E0E2, 1'b1, -1, 1'b0, '0, acc);
        tick(1'b0, '0, '0, 1'b0, -1, 1'b0, '0, acc);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("mid");
        q_wr.delete();
        q_wd.delete();
        q_ra.delete();
        q_rd.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(10);
        chk("post_reset_level", fifo_level, 0);

        chk("scoreboard_drained", q_wr.size() + q_wd.size() + q_ra.size() + q_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
